// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants for the lsu_master load/store unit: RV32I
//               funct3 codes, FSM state encoding, the fixed memory sign mask,
//               and small request-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // RV32I load/store funct3 codes (stores share B/H/W with loads)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_R0   = 3'd1;
  localparam logic [2:0] ST_R1   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_W0   = 3'd4;
  localparam logic [2:0] ST_W1   = 3'd5;
  localparam logic [2:0] ST_RESP = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  // Every memory access is a full unsigned word
  localparam logic [3:0] MEM_MASK_WORD = 4'b0111;

  // Access size in bytes from funct3[1:0]; the 2'b11 code is illegal and
  // rejected elsewhere, so its size value is irrelevant.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores only allow B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] | (f3[1:0] == 2'b11);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_master_if.sv
// ============================================================================
// Module      : lsu_master_if
// Description : Data-memory port bundle between lsu_master and data memory.
//   mem_addr        word-aligned byte address (bits[1:0] always 0)
//   mem_write_data  full word to store
//   mem_memwrite    write strobe
//   mem_memread     read strobe; data returns on mem_read_data next cycle
//   mem_sign_mask   access mask, fixed to word/unsigned
//   mem_read_data   read data, valid the cycle after mem_memread
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_master_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;

  modport master (
    output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    output mem_read_data
  );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational data path for lsu_master. Extracts and extends
//               load data from the two-word window {w1,w0}, and merges store
//               bytes into that window for read-modify-write.
//   w0_i, w1_i     low/high memory words of the access window
//   off_i          byte offset of the access within w0
//   funct3_i       RV32I funct3 (size and signedness)
//   wdata_i        right-aligned store data
//   load_data_o    extended load result
//   merged_lo_o    merged word for the low address
//   merged_hi_o    merged word for the high address
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_lo_o,
  output logic [31:0] merged_hi_o
);

  logic [63:0] w_window;
  logic [63:0] w_merged;
  logic [2:0]  w_size;

  assign w_size   = size_bytes(funct3_i);
  assign w_window = {w1_i, w0_i} >> {off_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{w_window[7]}},  w_window[7:0]};
      F3_BU:   load_data_o = {24'h0,              w_window[7:0]};
      F3_H:    load_data_o = {{16{w_window[15]}}, w_window[15:0]};
      F3_HU:   load_data_o = {16'h0,              w_window[15:0]};
      default: load_data_o = w_window[31:0];
    endcase
  end

  // Overwrite bytes off..off+size-1 of the 64-bit window; highest index is 6.
  always_comb begin
    w_merged = {w1_i, w0_i};
    for (int i = 0; i < 4; i++) begin
      if (i < int'(w_size)) begin
        w_merged[8*(int'(off_i) + i) +: 8] = wdata_i[8*i +: 8];
      end
    end
  end

  assign merged_lo_o = w_merged[31:0];
  assign merged_hi_o = w_merged[63:32];

endmodule

`default_nettype wire

// File: rtl/lsu_master.sv
// ============================================================================
// Module      : lsu_master
// Description : RV32I load/store initiator. Accepts one request at a time,
//               reads the one or two words covering the access, then either
//               returns the extracted load data or writes back merged words.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_funct3        RV32I size/sign code
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores/errors), held
//   resp_err          illegal funct3 or disallowed misalignment, held
//   busy              FSM not in IDLE
//   mem               data-memory port (lsu_master_if.master)
// Parameters  : MISALIGN_EN - 1 splits word-crossing accesses in two,
//                             0 rejects them with resp_err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_master
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_err,
  output logic         busy,
  lsu_master_if.master mem
);

  logic [2:0]  state_q, state_d;
  logic        we_q, span_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] w0_q, w0_d, w1_q, w1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_accept;
  logic        w_req_span;
  logic [31:0] w_a0, w_a1;
  logic [31:0] w_load, w_merged_lo, w_merged_hi;

  assign w_accept   = (state_q == ST_IDLE) && req_valid;
  // off (<=3) + size (<=4) fits in 3 bits without overflow
  assign w_req_span = (({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4);
  assign w_a0       = {addr_q[31:2], 2'b00};
  assign w_a1       = w_a0 + 32'd4;   // wraps 0xFFFFFFFC -> 0

  // Align/merge sees the words as they will be after this edge, so the load
  // result can be registered on the CAP -> RESP transition.
  lsu_align u_align (
    .w0_i        (w0_d),
    .w1_i        (w1_d),
    .off_i       (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q),
    .load_data_o (w_load),
    .merged_lo_o (w_merged_lo),
    .merged_hi_o (w_merged_hi)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = (f3_illegal(req_we, req_funct3) || (w_req_span && !MISALIGN_EN))
                  ? ST_ERR : ST_R0;
      end
      ST_R0:   state_d = span_q ? ST_R1 : ST_CAP;
      ST_R1:   state_d = ST_CAP;
      ST_CAP:  state_d = we_q ? ST_W0 : ST_RESP;
      ST_W0:   state_d = span_q ? ST_W1 : ST_RESP;
      ST_W1:   state_d = ST_RESP;
      default: state_d = ST_IDLE;   // RESP, ERR
    endcase
  end

  // Read data arrives one cycle after each read strobe: the R0 word lands in
  // R1 (spanning) or CAP (aligned); the R1 word lands in CAP.
  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    if ((state_q == ST_R1) || ((state_q == ST_CAP) && !span_q)) w0_d = mem.mem_read_data;
    if ((state_q == ST_CAP) && span_q)                          w1_d = mem.mem_read_data;
  end

  // Response data is loaded only when entering RESP/ERR and held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_d == ST_RESP) begin
      rdata_d = we_q ? 32'h0 : w_load;
      err_d   = 1'b0;
    end else if (state_d == ST_ERR) begin
      rdata_d = 32'h0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      span_q   <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      w0_q     <= 32'h0;
      w1_q     <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (w_accept) begin
        we_q     <= req_we;
        span_q   <= w_req_span;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Memory strobes decode straight from state, so a reset drops them at once.
  always_comb begin
    mem.mem_addr       = 32'h0;
    mem.mem_write_data = 32'h0;
    mem.mem_memread    = 1'b0;
    mem.mem_memwrite   = 1'b0;
    case (state_q)
      ST_R0: begin mem.mem_memread  = 1'b1; mem.mem_addr = w_a0; end
      ST_R1: begin mem.mem_memread  = 1'b1; mem.mem_addr = w_a1; end
      ST_W0: begin
        mem.mem_memwrite   = 1'b1;
        mem.mem_addr       = w_a0;
        mem.mem_write_data = w_merged_lo;
      end
      ST_W1: begin
        mem.mem_memwrite   = 1'b1;
        mem.mem_addr       = w_a1;
        mem.mem_write_data = w_merged_hi;
      end
      default: ;
    endcase
  end

  assign mem.mem_sign_mask = MEM_MASK_WORD;
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- CPU-side load/store initiator that drives the data memory port: addr, write_data, memwrite, memread, sign_mask in; read_data out with 1-cycle registered latency.
- Accepts one RV32I load/store request at a time. Issues only word-aligned full-word memory accesses.
- Performs byte/half extraction, sign extension, and read-modify-write merge for sub-word and misaligned (two-word) accesses.
- Sits between the EX/MEM pipeline stage and data memory. The core stalls on busy.

Parameters:
- MISALIGN_EN, 1, 1: misaligned accesses split into two word accesses; 0: misaligned request returns resp_err with no memory access.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe; accepted only when req_ready=1
- req_ready  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended; 0 for stores
- resp_err  out  1  illegal funct3, or misaligned with MISALIGN_EN=0
- busy  out  1  state != IDLE
- mem_addr  out  32  word-aligned address, bits[1:0]=0
- mem_write_data  out  32  merged word
- mem_memwrite  out  1  write strobe
- mem_memread  out  1  read strobe
- mem_sign_mask  out  4  constant 4'b0111 (word, unsigned)
- mem_read_data  in  32  valid the cycle after mem_memread

Behaviour:
- Reset, async, rst_n=0:
  - state=IDLE; all strobes 0; mem_addr=0; mem_write_data=0.
  - resp_valid=0; resp_rdata=0; resp_err=0; internal w0/w1=0.
- Reset mid-operation: abort immediately, no rollback. A completed W0 with W1 pending leaves a partial store in memory, which is accepted behaviour.
- Request decode:
  - size = 1/2/4 from funct3[1:0].
  - off = addr[1:0]; A0 = {addr[31:2],2'b00}; A1 = A0+4 modulo 2^32 (0xFFFFFFFC wraps to 0).
  - span = (off+size) > 4.
- State transitions:
  - IDLE: req_ready=1. On req_valid, latch all request fields.
    - Illegal funct3 (011, 110, 111; store funct3 >= 011), or span with MISALIGN_EN=0 -> ERR.
    - Otherwise -> R0.
  - R0: mem_memread=1, mem_addr=A0. -> R1 if span, else CAP.
  - R1: capture w0 from mem_read_data; mem_memread=1, mem_addr=A1. -> CAP.
  - CAP: capture last word (w1 if span, else w0). -> W0 if store, else RESP.
  - W0: mem_memwrite=1, mem_addr=A0, mem_write_data=merged low word. -> W1 if span, else RESP.
  - W1: mem_memwrite=1, mem_addr=A1, mem_write_data=merged high word. -> RESP.
  - RESP: resp_valid=1, resp_err=0. -> IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory strobes. -> IDLE.
- Strobe rules: mem_memread and mem_memwrite are never both high. Both are 0 outside R0/R1/W0/W1.
- Load data: window = {w1,w0} >> (8*off).
  - Byte: bits[7:0], sign-extended for LB, zero-extended for LBU.
  - Half: bits[15:0], sign-extended for LH, zero-extended for LHU.
  - Word: bits[31:0].
- Store merge: in 64-bit {w1,w0}, replace bytes off .. off+size-1 with req_wdata bytes 0 .. size-1. All other bytes are preserved.
- Latency from accept cycle T to resp_valid:
  - Aligned load: T+3.
  - Aligned store: T+4.
  - Spanning load: T+4.
  - Spanning store: T+6.
  - Error: T+1.
- Handshake: req_valid while busy (including RESP/ERR cycles) is ignored, not queued. resp_rdata and resp_err hold their values until the next response.
- LED register at 0x2000: reached via an ordinary word store (RMW). No special casing.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding: IDLE, R0, R1, CAP, W0, W1, RESP, ERR.
  - MEM_MASK_WORD=4'b0111.
- Sub-module lsu_align: purely combinational; inputs w0, w1, off, funct3, wdata; outputs load_data, merged_lo, merged_hi. The FSM stays in lsu_master.

Test Plan:
- Memory word 0x100 = 0x8899AABB; LB at 0x103 -> resp_rdata=0xFFFFFF88; LBU at 0x103 -> 0x00000088; resp_valid 3 cycles after accept.
- SH 0x1234 at 0x101 over 0x8899AABB -> one read, one write of 0x881234BB to 0x100; resp at T+4; no second write.
- LW at 0x0FE, with 0x0FC=0x44332211 and 0x100=0x88776655 -> reads 0x0FC then 0x100; resp_rdata=0x66554433 at T+4. With MISALIGN_EN=0 -> resp_err=1 at T+1, no strobes.
- SW 0xDEADBEEF at 0x0FF over the values above -> writes 0x0FC=0xEF332211 and 0x100=0x88DEADBE; LH at 0xFFFFFFFF -> second read at address 0x00000000.
- funct3=3'b011 load -> resp_err=1, resp_rdata=0, mem strobes never asserted; req_valid held high during busy -> exactly one accept.
- rst_n low during W0 of a spanning store -> next cycle state=IDLE, mem_memwrite=0, resp_valid=0, req_ready=1; W1 never issued.
